layer_sequencer: RTL

- Sequences the shared 18-neuron bank through the network's layers.
- Per layer: selects the layer, launches the neurons, waits for all done flags, then enables the layer connector to stream the 18 results over AXI-stream, counting accepted beats.
- Clears the neurons and advances to the next layer. Signals completion, or raises an error on a done-wait timeout.
- Sits between the top-level control (start/done) and the neuron bank plus layer connector.

---
 rtl/layer_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the shared neuron bank through every layer of one
// inference. For each layer it selects the weight bank, launches the neurons,
// waits for all done flags (with a timeout), lets the layer connector stream
// one beat per neuron, then clears the bank and moves to the next layer.
//
// Stream handshake: a beat is transferred in a cycle where stream_en,
// s_tvalid and s_tready are all high. s_tvalid alone or s_tready alone is
// not a beat, and nothing is counted outside STREAM.
//
// All outputs come straight from flops. Pulses and levels that follow the
// state are registered from the next state so they line up with it. The
// exception is neuron_start, which is registered from the current LAUNCH
// state, so it rises in the first WAIT_DONE cycle.
module layer_sequencer #(
    parameter int NUM_NEURONS    = 18,
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic [$clog2(NUM_LAYERS)-1:0]      layer_sel,
    output logic                               neuron_start,
    input  logic [NUM_NEURONS-1:0]             neuron_done,
    output logic                               neuron_clear,
    output logic                               stream_en,
    input  logic                               s_tvalid,
    input  logic                               s_tready,
    output logic [$clog2(NUM_NEURONS+1)-1:0]   beat_count,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [2:0]                         dbg_state
);

    localparam int LW = $clog2(NUM_LAYERS);
    localparam int BW = $clog2(NUM_NEURONS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_STREAM    = 3'd3,
        S_CLEAR     = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [LW-1:0]   r_layer_sel;
    logic [BW-1:0]   r_beat_count;
    logic [TW-1:0]   r_timer;
    logic            r_neuron_start;
    logic            r_neuron_clear;
    logic            r_stream_en;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic            w_start_acc;
    logic            w_all_done;
    logic            w_beat;
    logic            w_last_beat;
    logic            w_timeout;
    logic            w_last_layer;

    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_all_done   = &neuron_done;
    assign w_beat       = (r_state == S_STREAM) && s_tvalid && s_tready;
    assign w_last_beat  = w_beat && (r_beat_count == BW'(NUM_NEURONS - 1));
    assign w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_last_layer = (r_layer_sel == LW'(NUM_LAYERS - 1));

    // Next-state selection; done-flag completion has priority over timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_LAUNCH;
            S_LAUNCH:    w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (w_all_done)     w_next_state = S_STREAM;
                else if (w_timeout) w_next_state = S_ERROR;
            end
            S_STREAM:    if (w_last_beat) w_next_state = S_CLEAR;
            S_CLEAR:     w_next_state = w_last_layer ? S_FINISH : S_LAUNCH;
            S_FINISH:    w_next_state = S_IDLE;
            S_ERROR:     w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_neuron_start <= 1'b0;
            r_neuron_clear <= 1'b0;
            r_stream_en    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_neuron_start <= (r_state == S_LAUNCH);
            r_neuron_clear <= (w_next_state == S_CLEAR) || (w_next_state == S_ERROR);
            r_stream_en    <= (w_next_state == S_STREAM);
            r_busy         <= (w_next_state != S_IDLE);
            r_done         <= (w_next_state == S_FINISH);
            if (w_start_acc)
                r_error <= 1'b0;
            else if (w_next_state == S_ERROR)
                r_error <= 1'b1;
        end
    end

    // Layer index: zeroed on an accepted start, stepped when CLEAR loops back.
    always_ff @(posedge clk) begin
        if (reset)
            r_layer_sel <= '0;
        else if (w_start_acc)
            r_layer_sel <= '0;
        else if ((r_state == S_CLEAR) && !w_last_layer)
            r_layer_sel <= r_layer_sel + LW'(1);
    end

    // Done-wait timer: zeroed in LAUNCH, counts each incomplete WAIT_DONE cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_timer <= '0;
        else if (r_state == S_LAUNCH)
            r_timer <= '0;
        else if ((r_state == S_WAIT_DONE) && (w_next_state == S_WAIT_DONE))
            r_timer <= r_timer + TW'(1);
    end

    // Accepted-beat counter: zeroed on entry to STREAM, holds outside it.
    always_ff @(posedge clk) begin
        if (reset)
            r_beat_count <= '0;
        else if ((r_state == S_WAIT_DONE) && (w_next_state == S_STREAM))
            r_beat_count <= '0;
        else if (w_beat)
            r_beat_count <= r_beat_count + BW'(1);
    end

    assign layer_sel    = r_layer_sel;
    assign neuron_start = r_neuron_start;
    assign neuron_clear = r_neuron_clear;
    assign stream_en    = r_stream_en;
    assign beat_count   = r_beat_count;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign dbg_state    = r_state;

endmodule
